// File: rtl/count_seq_pkg.sv
// Shared types and constants for the count sequencer: FSM state encoding and mode values.
package count_seq_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/count_core.sv
// W-bit up counter datapath: synchronous clear has priority over enable.
module count_core #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] q
);
   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (clr)
         q_d = '0;
      else if (en)
         q_d = q_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q_q <= '0;
      else
         q_q <= q_d;
   end

   assign q = q_q;
endmodule

// File: rtl/count_seq_ctrl.sv
// Start/stop/pause sequencer around count_core with one-shot or periodic terminal count.
// Optional prescaler (presc port, tick every presc+1 cycles) enabled by COUNT_SEQ_PRESCALE_EN.
module count_seq_ctrl
   import count_seq_pkg::*;
#(
   parameter int W     = 3,
   parameter int PRE_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             mode,
   input  logic [W-1:0]     term,
`ifdef COUNT_SEQ_PRESCALE_EN
   input  logic [PRE_W-1:0] presc,
`endif
   output logic [W-1:0]     q,
   output logic             busy,
   output logic             tc,
   output logic             done
);
   state_t         state_q, state_d;
   logic [W-1:0]   term_q, term_d;
   logic           mode_q, mode_d;
   logic           busy_q, busy_d;
   logic           tc_q, tc_d;
   logic           done_q, done_d;
   logic           cnt_clr, cnt_en, tick;
   logic [W-1:0]   cnt_q;
`ifdef COUNT_SEQ_PRESCALE_EN
   logic [PRE_W-1:0] presc_q, presc_d;
   logic [PRE_W-1:0] pcnt_q, pcnt_d;
`endif

   count_core #(.W(W)) u_core (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .q     (cnt_q)
   );

   always_comb begin
      state_d = state_q;
      term_d  = term_q;
      mode_d  = mode_q;
      busy_d  = busy_q;
      done_d  = done_q;
      tc_d    = 1'b0;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
`ifdef COUNT_SEQ_PRESCALE_EN
      presc_d = presc_q;
      pcnt_d  = pcnt_q;
      tick    = (pcnt_q == presc_q);
`else
      tick    = 1'b1;
`endif
      if (stop) begin
         state_d = IDLE;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         cnt_clr = 1'b1;
`ifdef COUNT_SEQ_PRESCALE_EN
         pcnt_d  = '0;
`endif
      end else if (start) begin
         state_d = RUN;
         term_d  = term;
         mode_d  = mode;
         busy_d  = 1'b1;
         done_d  = 1'b0;
         cnt_clr = 1'b1;
`ifdef COUNT_SEQ_PRESCALE_EN
         presc_d = presc;
         pcnt_d  = '0;
`endif
      end else begin
         unique case (state_q)
            RUN: begin
               if (pause) begin
                  state_d = PAUSE;
               end else begin
`ifdef COUNT_SEQ_PRESCALE_EN
                  pcnt_d = tick ? '0 : pcnt_q + 1'b1;
`endif
                  // Terminal tick wraps via clear (periodic) or parks q at term (one-shot).
                  if (tick && (cnt_q == term_q)) begin
                     tc_d = 1'b1;
                     if (mode_q == MODE_PERIODIC) begin
                        cnt_clr = 1'b1;
                     end else begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                     end
                  end else if (tick) begin
                     cnt_en = 1'b1;
                  end
               end
            end
            PAUSE: begin
               if (!pause) begin
                  state_d = RUN;
`ifdef COUNT_SEQ_PRESCALE_EN
                  pcnt_d  = '0;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         term_q  <= '0;
         mode_q  <= MODE_ONESHOT;
         busy_q  <= 1'b0;
         tc_q    <= 1'b0;
         done_q  <= 1'b0;
`ifdef COUNT_SEQ_PRESCALE_EN
         presc_q <= '0;
         pcnt_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         term_q  <= term_d;
         mode_q  <= mode_d;
         busy_q  <= busy_d;
         tc_q    <= tc_d;
         done_q  <= done_d;
`ifdef COUNT_SEQ_PRESCALE_EN
         presc_q <= presc_d;
         pcnt_q  <= pcnt_d;
`endif
      end
   end

   assign q    = cnt_q;
   assign busy = busy_q;
   assign tc   = tc_q;
   assign done = done_q;
endmodule
